// File: rtl/seg_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_scan
// Brief    : Multiplexed N-digit seven-segment scanner with hex/raw decode,
//            digit mask, blank time, PWM brightness and frame strobe.
// Revision : 1.0
// ============================================================================
module seg_display_scan #(
    parameter int NUM_DIGITS    = 8,
    parameter int CLK_PER       = 10,
    parameter int REFR_RATE     = 1000,
    parameter int BLANK_CYC     = 16,
    parameter int ANODE_ACT_LOW = 1,
    parameter int SEG_ACT_LOW   = 1,
    localparam int c_IW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS*8-1:0] display,
    input  logic [NUM_DIGITS-1:0]   mode,
    input  logic [NUM_DIGITS-1:0]   en_mask,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    CA,
    output logic                    CB,
    output logic                    CC,
    output logic                    CD,
    output logic                    CE,
    output logic                    CF,
    output logic                    CG,
    output logic                    DP,
    output logic [c_IW-1:0]         digit_idx,
    output logic                    frame_tick
);

    localparam int   c_SLOT_CYC = 1_000_000_000 / (CLK_PER * REFR_RATE * NUM_DIGITS);
    localparam int   c_CW       = $clog2(c_SLOT_CYC + 1);
    localparam logic c_AN_INV   = (ANODE_ACT_LOW != 0);
    localparam logic c_SEG_INV  = (SEG_ACT_LOW != 0);

    if ((c_SLOT_CYC <= BLANK_CYC + 1) || (NUM_DIGITS < 1) || (NUM_DIGITS > 16)) begin : g_param_err
        $error("seg_display_scan: slot too short for blank time or NUM_DIGITS out of 1..16");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_ON    = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_CW-1:0]     r_cnt, w_cnt_nxt;
    logic [c_IW-1:0]     r_idx, w_idx_nxt;
    logic [3:0]          r_pwm;
    logic [7:0]          r_pat;
    logic [3:0]          r_bri;
    logic                r_ft, w_ft_nxt;
    logic                w_snap;

    logic                w_any;
    logic [c_IW-1:0]     w_lowest, w_next, w_j, w_tgt;
    logic                w_found;
    logic [7:0]          w_byte, w_pat_new;
    logic                w_lit;
    logic [NUM_DIGITS-1:0] w_an;
    logic [7:0]          w_seg;

    logic [NUM_DIGITS-1:0] r_an_o;
    logic [7:0]          r_seg_o;
    logic [c_IW-1:0]     r_idx_o;
    logic                r_ft_o;

    function automatic logic [6:0] f_hex7(input logic [3:0] i_nib);
        case (i_nib)
            4'h0: f_hex7 = 7'h3F;  4'h1: f_hex7 = 7'h06;
            4'h2: f_hex7 = 7'h5B;  4'h3: f_hex7 = 7'h4F;
            4'h4: f_hex7 = 7'h66;  4'h5: f_hex7 = 7'h6D;
            4'h6: f_hex7 = 7'h7D;  4'h7: f_hex7 = 7'h07;
            4'h8: f_hex7 = 7'h7F;  4'h9: f_hex7 = 7'h6F;
            4'hA: f_hex7 = 7'h77;  4'hB: f_hex7 = 7'h7C;
            4'hC: f_hex7 = 7'h39;  4'hD: f_hex7 = 7'h5E;
            4'hE: f_hex7 = 7'h79;  default: f_hex7 = 7'h71;
        endcase
    endfunction

    // Lowest enabled digit, and next enabled digit searching upward circularly
    always_comb begin
        w_any    = |en_mask;
        w_lowest = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (en_mask[i]) w_lowest = c_IW'(i);
        end
        w_next  = r_idx;
        w_found = 1'b0;
        w_j     = '0;
        for (int i = 1; i <= NUM_DIGITS; i++) begin
            w_j = c_IW'((int'(r_idx) + i) % NUM_DIGITS);
            if (!w_found && en_mask[w_j]) begin
                w_next  = w_j;
                w_found = 1'b1;
            end
        end
    end

    assign w_tgt     = (r_state == S_IDLE) ? w_lowest : w_next;
    assign w_byte    = display[{w_tgt, 3'b000} +: 8];
    assign w_pat_new = mode[w_tgt] ? w_byte : {w_byte[7], f_hex7(w_byte[3:0])};

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_ft_nxt    = 1'b0;
        w_snap      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = S_BLANK;
                    w_idx_nxt   = w_lowest;
                    w_cnt_nxt   = '0;
                    w_ft_nxt    = 1'b1;
                    w_snap      = 1'b1;
                end
            end
            S_BLANK: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_CW'(BLANK_CYC - 1)) w_state_nxt = S_ON;
            end
            S_ON: begin
                if (r_cnt == c_CW'(c_SLOT_CYC - 1)) begin
                    w_cnt_nxt = '0;
                    if (!w_any) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_BLANK;
                        w_idx_nxt   = w_next;
                        w_ft_nxt    = (w_next <= r_idx);
                        w_snap      = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_pwm   <= '0;
            r_pat   <= '0;
            r_bri   <= '0;
            r_ft    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_pwm   <= r_pwm + 1'b1;
            r_ft    <= w_ft_nxt;
            if (w_snap) begin
                r_pat <= w_pat_new;
                r_bri <= brightness;
            end
        end
    end

    assign w_lit = (r_bri == 4'hF) || (r_pwm < r_bri);

    always_comb begin
        w_an = '0;
        if ((r_state == S_ON) && w_lit) w_an[r_idx] = 1'b1;
        w_seg = (r_state == S_IDLE) ? 8'h00 : r_pat;
    end

    // Polarity is applied only here so reset lands directly on the inactive level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_an_o  <= {NUM_DIGITS{c_AN_INV}};
            r_seg_o <= {8{c_SEG_INV}};
            r_idx_o <= '0;
            r_ft_o  <= 1'b0;
        end else begin
            r_an_o  <= w_an ^ {NUM_DIGITS{c_AN_INV}};
            r_seg_o <= w_seg ^ {8{c_SEG_INV}};
            r_idx_o <= r_idx;
            r_ft_o  <= r_ft;
        end
    end

    assign AN                               = r_an_o;
    assign {DP, CG, CF, CE, CD, CC, CB, CA} = r_seg_o;
    assign digit_idx                        = r_idx_o;
    assign frame_tick                       = r_ft_o;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_scan
// Brief    : Self-checking bench; an active-low and an active-high instance
//            share stimulus and are compared against a slot/time model.
// Revision : 1.0
// ============================================================================
module tb_seg_display_scan;

    localparam int N     = 4;
    localparam int SLOT  = 20;
    localparam int BLANK = 4;
    localparam logic [6:0] c_HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] display = 32'h03_02_01_00;
    logic [3:0]  mode = 4'h0;
    logic [3:0]  en_mask = 4'hF;
    logic [3:0]  brightness = 4'hF;

    logic [3:0] an_a, an_b;
    logic [7:0] seg_a, seg_b;
    logic [1:0] idx_a, idx_b;
    logic       ft_a, ft_b;
    logic ca_a, cb_a, cc_a, cd_a, ce_a, cf_a, cg_a, dp_a;
    logic ca_b, cb_b, cc_b, cd_b, ce_b, cf_b, cg_b, dp_b;
    assign seg_a = {dp_a, cg_a, cf_a, ce_a, cd_a, cc_a, cb_a, ca_a};
    assign seg_b = {dp_b, cg_b, cf_b, ce_b, cd_b, cc_b, cb_b, ca_b};

    seg_display_scan #(.NUM_DIGITS(N), .CLK_PER(10), .REFR_RATE(1_250_000), .BLANK_CYC(BLANK),
                       .ANODE_ACT_LOW(1), .SEG_ACT_LOW(1)) dut_a (
        .clk(clk), .rst(rst_n), .display(display), .mode(mode), .en_mask(en_mask),
        .brightness(brightness), .AN(an_a), .CA(ca_a), .CB(cb_a), .CC(cc_a), .CD(cd_a),
        .CE(ce_a), .CF(cf_a), .CG(cg_a), .DP(dp_a), .digit_idx(idx_a), .frame_tick(ft_a));

    seg_display_scan #(.NUM_DIGITS(N), .CLK_PER(10), .REFR_RATE(1_250_000), .BLANK_CYC(BLANK),
                       .ANODE_ACT_LOW(0), .SEG_ACT_LOW(0)) dut_b (
        .clk(clk), .rst(rst_n), .display(display), .mode(mode), .en_mask(en_mask),
        .brightness(brightness), .AN(an_b), .CA(ca_b), .CB(cb_b), .CC(cc_b), .CD(cd_b),
        .CE(ce_b), .CF(cf_b), .CG(cg_b), .DP(dp_b), .digit_idx(idx_b), .frame_tick(ft_b));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int ft_seen  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Model: a slot is SLOT cycles old-age counted; first BLANK cycles are dark
    bit         m_active;
    int         m_digit, m_age, m_bri, m_pwm;
    logic [7:0] m_pat;
    bit         m_ft;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    int         e_idx;
    bit         e_ft;

    function automatic logic [7:0] pattern_for(input int d);
        logic [7:0] b;
        b = display[d*8 +: 8];
        if (mode[d]) return b;
        return {b[7], c_HEX[b[3:0]]};
    endfunction

    task automatic model_edge();
        int en_list[$];
        int nd;
        bit found;
        if (!rst_n) begin
            m_active = 0; m_digit = 0; m_age = 0; m_bri = 0; m_pwm = 0; m_pat = 8'h00; m_ft = 0;
            e_an = 4'h0; e_seg = 8'h00; e_idx = 0; e_ft = 0;
            return;
        end
        e_an = 4'h0;
        if (m_active && m_age >= BLANK && (m_bri == 15 || m_pwm < m_bri)) e_an[m_digit] = 1'b1;
        e_seg = m_active ? m_pat : 8'h00;
        e_idx = m_digit;
        e_ft  = m_ft;
        for (int d = 0; d < N; d++) if (en_mask[d]) en_list.push_back(d);
        m_ft = 0;
        if (!m_active) begin
            if (en_list.size() > 0) begin
                m_active = 1; m_digit = en_list[0]; m_age = 0; m_ft = 1;
                m_pat = pattern_for(m_digit); m_bri = int'(brightness);
            end
        end else if (m_age == SLOT - 1) begin
            m_age = 0;
            if (en_list.size() == 0) begin
                m_active = 0;
            end else begin
                nd = en_list[0];
                found = 0;
                for (int k = 0; k < en_list.size(); k++) begin
                    if (!found && en_list[k] > m_digit) begin
                        nd = en_list[k];
                        found = 1;
                    end
                end
                m_ft = (nd <= m_digit);
                m_digit = nd;
                m_pat = pattern_for(m_digit);
                m_bri = int'(brightness);
            end
        end else begin
            m_age++;
        end
        m_pwm = (m_pwm + 1) % 16;
    endtask

    task automatic step();
        logic [3:0] x_an;
        logic [7:0] x_seg;
        @(posedge clk);
        model_edge();
        #1;
        x_an  = ~e_an;
        x_seg = ~e_seg;
        check("an_a",  {28'b0, an_a},  {28'b0, x_an});
        check("seg_a", {24'b0, seg_a}, {24'b0, x_seg});
        check("an_b",  {28'b0, an_b},  {28'b0, e_an});
        check("seg_b", {24'b0, seg_b}, {24'b0, e_seg});
        check("idx_a", {30'b0, idx_a}, e_idx);
        check("idx_b", {30'b0, idx_b}, e_idx);
        check("ft_a",  {31'b0, ft_a},  {31'b0, e_ft});
        check("ft_b",  {31'b0, ft_b},  {31'b0, e_ft});
        if (ft_a) ft_seen++;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_mid_on(input string tag);
        int k;
        k = 0;
        while (!(m_active && m_age == 10) && k < 200) begin
            step();
            k++;
        end
        check(tag, {31'b0, (k < 200)}, 32'd1);
    endtask

    initial begin
        // Reset state
        run(3);
        check("rst_an_a",  {28'b0, an_a},  32'h0000_000F);
        check("rst_seg_a", {24'b0, seg_a}, 32'h0000_00FF);
        check("rst_an_b",  {28'b0, an_b},  32'h0);
        check("rst_seg_b", {24'b0, seg_b}, 32'h0);

        // Four digits, full brightness, hex 0..3
        rst_n = 1'b1;
        run(40);
        ft_seen = 0;
        run(800);
        check("ft_per_800", ft_seen, 32'd10);

        // Sparse mask
        en_mask = 4'b1010;
        run(200);

        // IDLE start, single digit, mask cleared mid-ON
        rst_n = 1'b0; en_mask = 4'h0;
        run(2);
        rst_n = 1'b1;
        run(30);
        en_mask = 4'b0100;
        run(60);
        wait_mid_on("wait_on_clear");
        en_mask = 4'h0;
        run(40);

        // PWM levels, including mid-slot change
        en_mask = 4'b0001; brightness = 4'd4;
        run(100);
        brightness = 4'd0;
        run(60);
        wait_mid_on("wait_on_bri");
        brightness = 4'd9;
        run(100);

        // Raw digit 0, hex digit 1 with DP
        display = 32'h0000_8F5A; mode = 4'b0001; en_mask = 4'b0011; brightness = 4'hF;
        run(60);
        begin
            int k;
            k = 0;
            while (!(e_idx == 1 && e_seg != 8'h00 && m_active) && k < 100) begin step(); k++; end
            check("hex_8F_b", {24'b0, seg_b}, 32'h0000_00F1);
            check("hex_8F_a", {24'b0, seg_a}, 32'h0000_000E);
            k = 0;
            while (!(e_idx == 0 && e_seg != 8'h00) && k < 100) begin step(); k++; end
            check("raw_5A_b", {24'b0, seg_b}, 32'h0000_005A);
        end

        // Reset mid-ON
        display = 32'h03_02_01_00; mode = 4'h0; en_mask = 4'b0110;
        run(60);
        wait_mid_on("wait_on_rst");
        rst_n = 1'b0;
        #1;
        check("rstmid_an_a",  {28'b0, an_a},  32'h0000_000F);
        check("rstmid_seg_a", {24'b0, seg_a}, 32'h0000_00FF);
        check("rstmid_an_b",  {28'b0, an_b},  32'h0);
        check("rstmid_seg_b", {24'b0, seg_b}, 32'h0);
        check("rstmid_ft",    {31'b0, ft_a},  32'h0);
        run(3);
        rst_n = 1'b1;
        run(100);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                case ($urandom_range(0, 3))
                    0: display = $urandom;
                    1: mode = 4'($urandom);
                    2: en_mask = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
                    default: brightness = 4'($urandom);
                endcase
            end
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                run(2);
                rst_n = 1'b1;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_display_scan.md
Name: seg_display_scan

Overview:
Parametrised multiplexed seven-segment scanner for N-digit common-anode boards. It adds several features to the basic fixed-8-digit refresh driver: per-digit hex-decode or raw mode, a digit-enable mask with skip, anti-ghosting blank time, 16-level PWM brightness, configurable output polarity and a frame-complete strobe. It sits between register-file/status logic and the board pins.

Parameters:
NUM_DIGITS, 8, digits scanned (1..16); sets widths of AN, display, mode, en_mask.
CLK_PER, 10, clock period in ns.
REFR_RATE, 1000, full-frame refresh rate in Hz.
BLANK_CYC, 16, dead-time cycles per slot with all anodes off.
ANODE_ACT_LOW, 1, 1 = AN pins active-low.
SEG_ACT_LOW, 1, 1 = cathode pins active-low.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
display  in  NUM_DIGITS*8  byte d at [d*8+:8]
mode  in  NUM_DIGITS  per digit: 0 = hex decode, 1 = raw {DP,G,F,E,D,C,B,A}
en_mask  in  NUM_DIGITS  1 = digit scanned
brightness  in  4  PWM level 0..15
AN  out  NUM_DIGITS  anode drives
CA,CB,CC,CD,CE,CF,CG,DP  out  1 each  cathode drives
digit_idx  out  $clog2(NUM_DIGITS) (min 1)  digit currently in its slot
frame_tick  out  1  one-cycle pulse when the scan wraps

Behaviour:
- SLOT_CYC = 1_000_000_000/(CLK_PER*REFR_RATE*NUM_DIGITS), integer. Elaboration error if SLOT_CYC <= BLANK_CYC+1 or NUM_DIGITS outside 1..16.
- Internal logic is active-high. The polarity params invert only at the output registers.
- Reset (rst=0, async): state IDLE, digit_idx=0, slot counter=0, pwm counter=0, frame_tick=0. All AN and cathodes are driven inactive: 1 when the matching *_ACT_LOW=1, else 0.
- FSM IDLE / BLANK / ON:
  - IDLE: all outputs inactive. When en_mask!=0, go to BLANK with digit_idx = lowest enabled index.
  - BLANK: lasts BLANK_CYC cycles. All anodes off. On entry, snapshot display byte, mode bit and brightness for digit_idx. Cathodes carry the new pattern.
  - ON: lasts SLOT_CYC-BLANK_CYC cycles. AN[digit_idx] is active when lit, and all other anodes are off.
  - End of ON, en_mask==0: go to IDLE.
  - End of ON, otherwise: next = first enabled index searching upward circularly from digit_idx+1. If only the current digit is enabled, next = digit_idx. Then go to BLANK.
- frame_tick: asserted the cycle BLANK is entered when next <= previous digit_idx (wrap or single digit). Also asserted on the IDLE->BLANK entry.
- PWM: a 4-bit counter increments every clock and wraps 15->0.
  - lit = 1 if snapped brightness==15, else (pwm_cnt < snapped brightness).
  - brightness 0 = dark. 15 = fully on during ON.
- Hex decode on nibble display[d*8+:4], pattern in gfedcba order: 0 3F, 1 06, 2 5B, 3 4F, 4 66, 5 6D, 6 7D, 7 07, 8 7F, 9 6F, A 77, b 7C, C 39, d 5E, E 79, F 71.
  - In hex mode DP = display bit 7, and bits 6:4 are ignored.
  - In raw mode the byte is used verbatim.
- All outputs are registered, one cycle behind state. An input change mid-slot has no effect until the next BLANK entry. An en_mask change takes effect only at slot end.
- Reset mid-slot: outputs go inactive immediately, with no glitch to an active level.

Test Plan:
1. NUM_DIGITS=4, CLK_PER=10, REFR_RATE=1_250_000 (SLOT_CYC=20), BLANK_CYC=4, en_mask=F, brightness=15, mode=0, display=32'h03_02_01_00.
   -> digits go active in order 0,1,2,3,0. Each AN is low for exactly 16 cycles per slot, with 4-cycle all-high gaps.
   -> cathode bytes (active-low) C0,F9,A4,B0.
   -> frame_tick fires once every 80 cycles.
2. Same setup, en_mask=4'b1010.
   -> only digits 1,3 scanned, alternating every 20 cycles.
   -> frame_tick on every entry to digit 1. AN[0], AN[2] never active.
3. en_mask=0 from reset, then set to 4'b0100.
   -> outputs stay inactive in IDLE.
   -> BLANK is entered next cycle with digit_idx=2, then the single digit repeats with frame_tick every 20 cycles.
   -> en_mask cleared mid-ON returns to IDLE only after the slot ends.
4. brightness=4, one digit enabled.
   -> within ON, AN is active exactly 4 of every 16 cycles.
   -> brightness=0 gives no active AN cycles.
   -> changing brightness mid-slot applies from the next slot.
5. mode=4'b0001, display[7:0]=8'h5A, SEG_ACT_LOW=0, ANODE_ACT_LOW=0.
   -> digit 0 cathodes {DP..CA} = 5A raw, AN active-high.
   -> hex digit with display byte 8'h8F gives 71 with DP=1.
6. Assert rst mid-ON.
   -> same cycle AN/cathodes go inactive.
   -> after release, scan restarts from the lowest enabled digit with a fresh BLANK.
